// File: rtl/rv_sdram_initiator_pkg.sv
// Shared types and constants for the RISC-V to SDRAM toggle-handshake initiator.
// Optional watchdog is enabled by defining RV_INITIATOR_TIMEOUT_EN.
package rv_sdram_initiator_pkg;

  localparam int RV_ADDR_W  = 20;
  localparam int RV_DATA_W  = 16;
  localparam int CPU_ADDR_W = 19;

  localparam logic [1:0]  DS_BOTH       = 2'b11;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_LO,
    WAIT_LO,
    CAP_LO,
    ISSUE_HI,
    WAIT_HI,
    CAP_HI,
    DONE
  } state_e;

endpackage

// File: rtl/rv_sdram_initiator_if.sv
// Softcore valid/ready word bus plus the controller's halfword toggle-handshake port.
// master = the initiator, slave = the core/controller environment around it.
interface rv_sdram_initiator_if;
  import rv_sdram_initiator_pkg::*;

  logic                  cpu_valid;
  logic                  cpu_ready;
  logic [CPU_ADDR_W-1:0] cpu_addr;
  logic [3:0]            cpu_wstrb;
  logic [31:0]           cpu_wdata;
  logic [31:0]           cpu_rdata;
  logic                  cpu_err;

  logic [RV_ADDR_W-1:0]  rv_addr;
  logic [RV_DATA_W-1:0]  rv_din;
  logic [1:0]            rv_ds;
  logic                  rv_we;
  logic                  rv_req;
  logic                  rv_req_ack;
  logic [RV_DATA_W-1:0]  rv_dout;

  modport master (
    input  cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata, rv_req_ack, rv_dout,
    output cpu_ready, cpu_rdata, cpu_err, rv_addr, rv_din, rv_ds, rv_we, rv_req
  );

  modport slave (
    output cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata, rv_req_ack, rv_dout,
    input  cpu_ready, cpu_rdata, cpu_err, rv_addr, rv_din, rv_ds, rv_we, rv_req
  );

endinterface

// File: rtl/rv_sdram_initiator.sv
// Splits 32-bit core requests into one or two 16-bit toggle-handshake accesses.
// Define RV_INITIATOR_TIMEOUT_EN to add a per-access ack watchdog (TIMEOUT_CYCLES).
module rv_sdram_initiator
  import rv_sdram_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  rv_sdram_initiator_if.master bus
);

  state_e                state_reg, state_next;
  logic [CPU_ADDR_W-1:0] addr_reg, addr_next;
  logic [3:0]            wstrb_reg, wstrb_next;
  logic [31:0]           wdata_reg, wdata_next;
  logic                  is_write_reg, is_write_next;
  logic [31:0]           rdata_reg, rdata_next;
  logic                  err_reg, err_next;
  logic                  rv_req_reg, rv_req_next;
  logic [RV_ADDR_W-1:0]  rv_addr_reg, rv_addr_next;
  logic [RV_DATA_W-1:0]  rv_din_reg, rv_din_next;
  logic [1:0]            rv_ds_reg, rv_ds_next;
  logic                  rv_we_reg, rv_we_next;

  logic handshake_idle;
  logic timeout;

  // Doubles as "ack observed" in WAIT and "nothing outstanding" in ISSUE; the
  // latter also absorbs a late ack left behind by a watchdog abort.
  assign handshake_idle = (bus.rv_req_ack == rv_req_reg);

`ifdef RV_INITIATOR_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;

  always_comb begin
    wd_cnt_next = wd_cnt_reg;
    case (state_reg)
      ISSUE_LO, ISSUE_HI: wd_cnt_next = '0;
      WAIT_LO, WAIT_HI:   wd_cnt_next = wd_cnt_reg + WD_W'(1);
      default:            wd_cnt_next = wd_cnt_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wd_cnt_reg <= '0;
    end else begin
      wd_cnt_reg <= wd_cnt_next;
    end
  end

  assign timeout = ((state_reg == WAIT_LO) || (state_reg == WAIT_HI)) && !handshake_idle &&
                   (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    wstrb_next    = wstrb_reg;
    wdata_next    = wdata_reg;
    is_write_next = is_write_reg;
    rdata_next    = rdata_reg;
    err_next      = err_reg;
    rv_req_next   = rv_req_reg;
    rv_addr_next  = rv_addr_reg;
    rv_din_next   = rv_din_reg;
    rv_ds_next    = rv_ds_reg;
    rv_we_next    = rv_we_reg;

    case (state_reg)
      IDLE: begin
        if (bus.cpu_valid) begin
          addr_next     = bus.cpu_addr;
          wstrb_next    = bus.cpu_wstrb;
          wdata_next    = bus.cpu_wdata;
          is_write_next = |bus.cpu_wstrb;
          err_next      = 1'b0;
          // Only an upper-lane-only write skips the low halfword.
          if ((bus.cpu_wstrb != 4'b0000) && (bus.cpu_wstrb[1:0] == 2'b00)) begin
            state_next = ISSUE_HI;
          end else begin
            state_next = ISSUE_LO;
          end
        end
      end

      ISSUE_LO: begin
        if (handshake_idle) begin
          rv_req_next  = ~rv_req_reg;
          rv_addr_next = {addr_reg, 1'b0};
          rv_ds_next   = is_write_reg ? wstrb_reg[1:0] : DS_BOTH;
          rv_din_next  = wdata_reg[15:0];
          rv_we_next   = is_write_reg;
          state_next   = WAIT_LO;
        end
      end

      WAIT_LO: begin
        if (handshake_idle) begin
          if (!is_write_reg) begin
            state_next = CAP_LO;
          end else if (wstrb_reg[3:2] != 2'b00) begin
            state_next = ISSUE_HI;
          end else begin
            state_next = DONE;
          end
        end else if (timeout) begin
          err_next   = 1'b1;
          rdata_next = is_write_reg ? rdata_reg : TIMEOUT_RDATA;
          state_next = DONE;
        end
      end

      CAP_LO: begin
        rdata_next[15:0] = bus.rv_dout;
        state_next       = ISSUE_HI;
      end

      ISSUE_HI: begin
        if (handshake_idle) begin
          rv_req_next  = ~rv_req_reg;
          rv_addr_next = {addr_reg, 1'b1};
          rv_ds_next   = is_write_reg ? wstrb_reg[3:2] : DS_BOTH;
          rv_din_next  = wdata_reg[31:16];
          rv_we_next   = is_write_reg;
          state_next   = WAIT_HI;
        end
      end

      WAIT_HI: begin
        if (handshake_idle) begin
          state_next = is_write_reg ? DONE : CAP_HI;
        end else if (timeout) begin
          err_next   = 1'b1;
          rdata_next = is_write_reg ? rdata_reg : TIMEOUT_RDATA;
          state_next = DONE;
        end
      end

      CAP_HI: begin
        rdata_next[31:16] = bus.rv_dout;
        state_next        = DONE;
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      wstrb_reg    <= '0;
      wdata_reg    <= '0;
      is_write_reg <= 1'b0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
      rv_req_reg   <= 1'b0;
      rv_addr_reg  <= '0;
      rv_din_reg   <= '0;
      rv_ds_reg    <= 2'b00;
      rv_we_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      wstrb_reg    <= wstrb_next;
      wdata_reg    <= wdata_next;
      is_write_reg <= is_write_next;
      rdata_reg    <= rdata_next;
      err_reg      <= err_next;
      rv_req_reg   <= rv_req_next;
      rv_addr_reg  <= rv_addr_next;
      rv_din_reg   <= rv_din_next;
      rv_ds_reg    <= rv_ds_next;
      rv_we_reg    <= rv_we_next;
    end
  end

  assign bus.cpu_ready = (state_reg == DONE);
  assign bus.cpu_rdata = rdata_reg;
  assign bus.cpu_err   = err_reg;
  assign bus.rv_req    = rv_req_reg;
  assign bus.rv_addr   = rv_addr_reg;
  assign bus.rv_din    = rv_din_reg;
  assign bus.rv_ds     = rv_ds_reg;
  assign bus.rv_we     = rv_we_reg;

endmodule
